// File: rtl/readout_sequencer.sv
// readout_sequencer: walks the NCH channel sample RAMs from the oldest pre-trigger sample and streams the bytes to the host link.
// Latency: first tx_valid rises RD_LAT+1 edges after a start is accepted with data_ready high; one byte/cycle within a channel.
// Backpressure: tx_ready low stalls FIFO pops; reads are only issued against free FIFO credit, so returning data is never dropped.
module readout_sequencer #(
  parameter int ram_width  = 10,
  parameter int NCH        = 4,
  parameter int RD_LAT     = 2,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                    clk,
  input  logic                    rstn,
  input  logic                    start_readout,
  input  logic                    abort,
  input  logic                    auto_rearm,
  input  logic                    data_ready,
  input  logic [ram_width-1:0]    wraddress_triggerpoint,
  input  logic [ram_width-1:0]    triggerpoint,
  input  logic [ram_width-1:0]    nsmp,
  output logic                    rden,
  output logic [ram_width-1:0]    rdaddress,
  output logic [$clog2(NCH)-1:0]  ch_sel,
  input  logic [7:0]              rddata,
  output logic [7:0]              tx_data,
  output logic                    tx_valid,
  input  logic                    tx_ready,
  output logic                    busy,
  output logic                    readout_done,
  output logic                    rearm
);

  localparam int CHW = $clog2(NCH);
  localparam int PW  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW  = $clog2(FIFO_DEPTH + 1);
  localparam int SW  = $clog2(FIFO_DEPTH + RD_LAT + 1);
  localparam logic [ram_width-1:0] A_ONE   = ram_width'(1);
  localparam logic [CHW-1:0]       CH_ONE  = CHW'(1);
  localparam logic [CHW-1:0]       CH_LAST = CHW'(NCH - 1);

  typedef enum logic [2:0] {S_IDLE, S_WAITRDY, S_READ, S_CHSW, S_DRAIN, S_DONE} state_t;

  state_t               r_state, w_next;
  logic [ram_width-1:0] r_base, r_n, r_idx;
  logic [CHW-1:0]       r_ch;
  logic [RD_LAT-1:0]    r_vld;
  logic [7:0]           r_mem [FIFO_DEPTH];
  logic [PW-1:0]        r_wp, r_rp;
  logic [CW-1:0]        r_cnt;
  logic [SW-1:0]        w_inflight;
  logic                 w_credit, w_issue, w_push, w_pop, w_accept, w_ch_adv;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(FIFO_DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  // Count reads sitting in the RAM pipeline whose bytes have not yet reached the FIFO
  always_comb begin
    w_inflight = '0;
    for (int i = 0; i < RD_LAT; i++) w_inflight = w_inflight + SW'(r_vld[i]);
  end

  // A read may only be issued if its byte is guaranteed a FIFO slot on return
  assign w_credit = (SW'(r_cnt) + w_inflight) < SW'(FIFO_DEPTH);

  // Next-state and read-issue decode; abort overrides everything
  always_comb begin
    w_next  = r_state;
    w_issue = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start_readout) begin
          if (!data_ready)      w_next = S_WAITRDY;
          else if (nsmp == '0)  w_next = S_DONE;
          else                  w_next = S_READ;
        end
      end
      S_WAITRDY: if (data_ready) w_next = (r_n == '0) ? S_DONE : S_READ;
      S_READ: begin
        if (w_credit) begin
          w_issue = 1'b1;
          if (r_idx == r_n - A_ONE) w_next = (r_ch == CH_LAST) ? S_DRAIN : S_CHSW;
        end
      end
      S_CHSW:  if (w_inflight == '0) w_next = S_READ;
      S_DRAIN: if (w_inflight == '0 && r_cnt == '0) w_next = S_DONE;
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
    if (abort) begin
      w_next  = S_IDLE;
      w_issue = 1'b0;
    end
  end

  assign w_accept = (r_state == S_IDLE) && start_readout && !abort;
  assign w_ch_adv = (r_state == S_CHSW) && (w_next == S_READ);
  assign w_push   = r_vld[RD_LAT-1];
  assign w_pop    = tx_valid & tx_ready;

  // State register
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  // Latch capture geometry at start, then walk sample index and channel
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_base <= '0;
      r_n    <= '0;
      r_idx  <= '0;
      r_ch   <= '0;
    end else if (abort) begin
      r_idx <= '0;
      r_ch  <= '0;
    end else if (w_accept) begin
      r_base <= wraddress_triggerpoint - triggerpoint;
      r_n    <= nsmp;
      r_idx  <= '0;
      r_ch   <= '0;
    end else if (w_ch_adv) begin
      r_idx <= '0;
      r_ch  <= r_ch + CH_ONE;
    end else if (w_issue) begin
      r_idx <= r_idx + A_ONE;
    end
  end

  // Valid shift mirroring rden through the RAM read latency
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn || abort) begin
      r_vld <= '0;
    end else begin
      r_vld[0] <= w_issue;
      for (int i = 1; i < RD_LAT; i++) r_vld[i] <= r_vld[i-1];
    end
  end

  // FIFO pointers and occupancy; abort discards everything queued
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_wp  <= '0;
      r_rp  <= '0;
      r_cnt <= '0;
    end else if (abort) begin
      r_wp  <= '0;
      r_rp  <= '0;
      r_cnt <= '0;
    end else begin
      if (w_push) r_wp <= ptr_inc(r_wp);
      if (w_pop)  r_rp <= ptr_inc(r_rp);
      case ({w_push, w_pop})
        2'b10:   r_cnt <= r_cnt + CW'(1);
        2'b01:   r_cnt <= r_cnt - CW'(1);
        default: r_cnt <= r_cnt;
      endcase
    end
  end

  // FIFO storage; contents are only observable through the gated head
  always_ff @(posedge clk) begin
    if (w_push && !abort) r_mem[r_wp] <= rddata;
  end

  assign rden         = w_issue;
  assign rdaddress    = r_base + r_idx;
  assign ch_sel       = r_ch;
  assign tx_valid     = (r_cnt != '0);
  assign tx_data      = tx_valid ? r_mem[r_rp] : 8'h00;
  assign busy         = (r_state != S_IDLE);
  assign readout_done = (r_state == S_DONE) && !abort;
  assign rearm        = readout_done && auto_rearm;

endmodule

// File: tb/tb_readout_sequencer.sv
// Bench for readout_sequencer: table-driven transactions, hand-written corner sequences and randomized runs.
// Expected address/byte streams come from a queue model built from capture geometry with plain arithmetic.
// A simple two-stage RAM model returns 16*ch + addr (+ a high-address term) for each read.
module tb_readout_sequencer;
  localparam int AW = 10, NCH = 4, RD_LAT = 2, FIFO_DEPTH = 4;
  localparam int AMOD = 1 << AW;

  logic          clk = 1'b0, rstn = 1'b0;
  logic          start_readout = 1'b0, abort = 1'b0, auto_rearm = 1'b0, data_ready = 1'b0;
  logic [AW-1:0] wraddress_triggerpoint = '0, triggerpoint = '0, nsmp = '0;
  logic          rden, tx_valid, busy, readout_done, rearm;
  logic          tx_ready = 1'b1;
  logic [AW-1:0] rdaddress;
  logic [1:0]    ch_sel;
  logic [7:0]    rddata, tx_data;

  readout_sequencer #(.ram_width(AW), .NCH(NCH), .RD_LAT(RD_LAT), .FIFO_DEPTH(FIFO_DEPTH)) dut (
    .clk(clk), .rstn(rstn), .start_readout(start_readout), .abort(abort), .auto_rearm(auto_rearm),
    .data_ready(data_ready), .wraddress_triggerpoint(wraddress_triggerpoint), .triggerpoint(triggerpoint),
    .nsmp(nsmp), .rden(rden), .rdaddress(rdaddress), .ch_sel(ch_sel), .rddata(rddata),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready), .busy(busy),
    .readout_done(readout_done), .rearm(rearm));

  always #5 clk = ~clk;

  // RAM content seen by the sequencer
  function automatic logic [7:0] ram_val(input int ch, input int addr);
    int v;
    v = 16 * ch + addr + 3 * (addr >> 8);
    return v[7:0];
  endfunction

  // Registered-address, registered-output RAM (two cycles of read latency)
  logic [AW-1:0] ram_a1 = '0, ram_a2 = '0;
  always @(posedge clk) begin
    if (rden) ram_a1 <= rdaddress;
    ram_a2 <= ram_a1;
  end
  assign rddata = ram_val(int'(ch_sel), int'(ram_a2));

  int checks = 0, errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Observation state, owned by the initial block
  int addr_q[$], ach_q[$], rx_q[$];
  int n_done, n_rearm, n_rearm_alone, rx_at_done, chsw_viol, valid_viol, occ, occ_max;
  bit h1, h2;
  logic [1:0] prev_ch;

  task automatic clear_obs();
    addr_q.delete(); ach_q.delete(); rx_q.delete();
    n_done = 0; n_rearm = 0; n_rearm_alone = 0; rx_at_done = -1;
    chsw_viol = 0; valid_viol = 0; occ = 0; occ_max = 0; h1 = 0; h2 = 0;
    prev_ch = ch_sel;
  endtask

  // Observe at the falling edge what the next rising edge will commit, then advance
  task automatic tick();
    @(negedge clk);
    if (tx_valid !== (occ > 0)) valid_viol++;
    if (ch_sel !== prev_ch && (h1 || h2)) chsw_viol++;
    prev_ch = ch_sel;
    if (rden === 1'b1) begin
      addr_q.push_back(int'(rdaddress));
      ach_q.push_back(int'(ch_sel));
    end
    if (tx_valid && tx_ready) rx_q.push_back(int'(tx_data));
    if (readout_done) begin n_done++; rx_at_done = rx_q.size(); end
    if (rearm) begin n_rearm++; if (!readout_done) n_rearm_alone++; end
    occ = occ + (h2 ? 1 : 0) - ((tx_valid && tx_ready) ? 1 : 0);
    if (occ > occ_max) occ_max = occ;
    h2 = h1;
    h1 = (rden === 1'b1);
    if (abort) begin occ = 0; h1 = 0; h2 = 0; end
    @(posedge clk); #1;
  endtask

  // One complete readout compared against the reference model
  task automatic run_txn(input string tag, input int wtp, input int tp, input int n, input int ar, input int rnd);
    int exp_addr[$], exp_ch[$], exp_byte[$];
    int base, cyc, m;
    base = (wtp - tp + AMOD) % AMOD;
    for (int c = 0; c < NCH; c++)
      for (int i = 0; i < n; i++) begin
        exp_addr.push_back((base + i) % AMOD);
        exp_ch.push_back(c);
        exp_byte.push_back(int'(ram_val(c, (base + i) % AMOD)));
      end
    clear_obs();
    wraddress_triggerpoint = AW'(wtp);
    triggerpoint = AW'(tp);
    nsmp = AW'(n);
    auto_rearm = ar[0];
    data_ready = 1'b1;
    tx_ready = 1'b1;
    start_readout = 1'b1;
    tick();
    start_readout = 1'b0;
    cyc = 0;
    while (n_done == 0 && cyc < 4000) begin
      if (rnd != 0) begin
        tx_ready = 1'($urandom_range(0, 1));
        data_ready = 1'($urandom_range(0, 1));
        if (cyc == 5 && busy) begin
          start_readout = 1'b1;
          wraddress_triggerpoint = AW'($urandom);
          triggerpoint = AW'($urandom);
          nsmp = AW'($urandom_range(0, 50));
        end else begin
          start_readout = 1'b0;
        end
      end
      tick();
      cyc++;
    end
    start_readout = 1'b0;
    tx_ready = 1'b1;
    data_ready = 1'b1;
    repeat (4) tick();
    check({tag, " completes_in_budget"}, (cyc < 4000) ? 1 : 0, 1);
    check({tag, " byte_count"}, rx_q.size(), exp_byte.size());
    m = (rx_q.size() < exp_byte.size()) ? rx_q.size() : exp_byte.size();
    for (int i = 0; i < m; i++) check($sformatf("%s byte[%0d]", tag, i), rx_q[i], exp_byte[i]);
    check({tag, " read_count"}, addr_q.size(), exp_addr.size());
    m = (addr_q.size() < exp_addr.size()) ? addr_q.size() : exp_addr.size();
    for (int i = 0; i < m; i++) begin
      check($sformatf("%s rdaddress[%0d]", tag, i), addr_q[i], exp_addr[i]);
      check($sformatf("%s ch_sel[%0d]", tag, i), ach_q[i], exp_ch[i]);
    end
    check({tag, " done_pulses"}, n_done, 1);
    check({tag, " rearm_pulses"}, n_rearm, ar);
    check({tag, " rearm_without_done"}, n_rearm_alone, 0);
    check({tag, " bytes_before_done"}, rx_at_done, exp_byte.size());
    check({tag, " ch_sel_changed_in_flight"}, chsw_viol, 0);
    check({tag, " tx_valid_vs_occupancy"}, valid_viol, 0);
    check({tag, " fifo_within_depth"}, (occ_max <= FIFO_DEPTH) ? 1 : 0, 1);
    check({tag, " idle_after"}, busy, 0);
  endtask

  typedef struct {
    int wtp; int tp; int n; int ar; int rnd;
    int exp_first; int exp_last; int exp_bytes;
  } vec_t;

  vec_t vecs[6];

  initial begin
    int edges, cyc, cnt;
    vecs[0] = '{5,    3,   8,  0, 0, 2,    9,   32};
    vecs[1] = '{2,    5,   8,  1, 0, 1021, 4,   32};
    vecs[2] = '{100,  10,  4,  0, 1, 90,   93,  16};
    vecs[3] = '{0,    0,   0,  1, 0, 0,    0,   0};
    vecs[4] = '{1023, 1,   3,  1, 1, 1022, 0,   12};
    vecs[5] = '{700,  300, 20, 0, 1, 400,  419, 80};

    // Reset values
    repeat (3) @(posedge clk);
    #1;
    check("rst rden", rden, 0);
    check("rst rdaddress", rdaddress, 0);
    check("rst ch_sel", ch_sel, 0);
    check("rst tx_valid", tx_valid, 0);
    check("rst tx_data", tx_data, 0);
    check("rst busy", busy, 0);
    check("rst readout_done", readout_done, 0);
    check("rst rearm", rearm, 0);
    @(negedge clk) rstn = 1'b1;
    @(posedge clk); #1;

    // Table-driven transactions
    for (int k = 0; k < 6; k++) begin
      run_txn($sformatf("vec%0d", k), vecs[k].wtp, vecs[k].tp, vecs[k].n, vecs[k].ar, vecs[k].rnd);
      check($sformatf("vec%0d total_bytes", k), rx_q.size(), vecs[k].exp_bytes);
      if (vecs[k].n > 0) begin
        check($sformatf("vec%0d first_addr", k), (addr_q.size() > 0) ? addr_q[0] : -1, vecs[k].exp_first);
        check($sformatf("vec%0d last_addr", k), (addr_q.size() > 0) ? addr_q[addr_q.size()-1] : -1, vecs[k].exp_last);
      end
    end

    // nsmp=0 waiting for data_ready: done one cycle after data_ready is seen, rearm coincident
    data_ready = 1'b0; nsmp = '0; auto_rearm = 1'b1; start_readout = 1'b1;
    @(posedge clk); #1;
    start_readout = 1'b0;
    check("n0 waiting busy", busy, 1);
    check("n0 waiting done", readout_done, 0);
    @(posedge clk); #1;
    check("n0 still waiting done", readout_done, 0);
    check("n0 still waiting rden", rden, 0);
    data_ready = 1'b1;
    @(posedge clk); #1;
    check("n0 done", readout_done, 1);
    check("n0 rearm", rearm, 1);
    check("n0 rden", rden, 0);
    @(posedge clk); #1;
    check("n0 done_cleared", readout_done, 0);
    check("n0 rearm_cleared", rearm, 0);
    check("n0 idle", busy, 0);

    // First-byte latency, then abort in the middle of channel 2
    wraddress_triggerpoint = AW'(50); triggerpoint = AW'(20); nsmp = AW'(8);
    auto_rearm = 1'b1; tx_ready = 1'b1; start_readout = 1'b1;
    @(posedge clk); #1;
    start_readout = 1'b0;
    edges = 0;
    while (!tx_valid && edges < 20) begin @(posedge clk); #1; edges++; end
    check("first_valid_edges", edges, RD_LAT + 1);
    check("first_byte", tx_data, ram_val(0, 30));
    cyc = 0;
    while (ch_sel != 2'd2 && cyc < 100) begin @(posedge clk); #1; cyc++; end
    check("reached_ch2", ch_sel, 2);
    @(posedge clk); #1;
    abort = 1'b1; start_readout = 1'b1;
    #1;
    check("abort rden", rden, 0);
    check("abort done", readout_done, 0);
    @(posedge clk); #1;
    abort = 1'b0; start_readout = 1'b0;
    check("abort busy", busy, 0);
    check("abort tx_valid", tx_valid, 0);
    check("abort ch_sel", ch_sel, 0);
    check("abort tx_data", tx_data, 0);
    cnt = 0;
    repeat (6) begin @(posedge clk); #1; if (readout_done || rearm) cnt++; end
    check("abort no_done_or_rearm", cnt, 0);

    // abort and start together in IDLE: abort wins
    abort = 1'b1; start_readout = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0; start_readout = 1'b0;
    check("abort_vs_start busy", busy, 0);

    // Reset pulse in the middle of READ
    wraddress_triggerpoint = AW'(40); triggerpoint = AW'(0); nsmp = AW'(30);
    auto_rearm = 1'b0; start_readout = 1'b1;
    @(posedge clk); #1;
    start_readout = 1'b0;
    cyc = 0;
    while (ch_sel != 2'd1 && cyc < 200) begin @(posedge clk); #1; cyc++; end
    check("reached_ch1", ch_sel, 1);
    #2 rstn = 1'b0;
    #1;
    check("midrst rden", rden, 0);
    check("midrst rdaddress", rdaddress, 0);
    check("midrst ch_sel", ch_sel, 0);
    check("midrst tx_valid", tx_valid, 0);
    check("midrst tx_data", tx_data, 0);
    check("midrst busy", busy, 0);
    check("midrst done", readout_done, 0);
    @(negedge clk) rstn = 1'b1;
    @(posedge clk); #1;
    run_txn("post_reset", 5, 3, 8, 0, 0);

    // Randomized transactions with back-pressure and ignored input changes
    for (int r = 0; r < 8; r++)
      run_txn($sformatf("rand%0d", r), int'($urandom_range(0, AMOD - 1)), int'($urandom_range(0, AMOD - 1)),
              int'($urandom_range(1, 40)), int'($urandom_range(0, 1)), 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
